// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU front end: sequencer FSM states and
// default PC vectors.
package cpu16_pkg;

  localparam int PC_AW = 16;

  localparam logic [PC_AW-1:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [PC_AW-1:0] TRAP_VEC_DEF  = 16'h0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry; a pop of an empty stack leaves it untouched.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_ptr_dec;

  // r_ptr is the next write slot; once full it also points at the oldest entry
  assign w_ptr_dec = r_ptr - PW'(1);
  assign top       = r_mem[w_ptr_dec];
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + PW'(1);
      if (!full) r_count <= r_count + (PW+1)'(1);
    end else if (pop && !empty) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC, arbitrates branch/jump/call/return/trap,
// handles stall and halt. Return stack present only with PC_SEQ_RAS_EN.
//
// state   | meaning
// BOOT    | first cycle out of reset, PC = RESET_VEC, nothing executes
// RUN     | fetching and executing, PC advances per request priority
// HALT    | PC frozen, waiting for resume
module pc_sequencer
  import cpu16_pkg::*;
#(
  parameter int             AW        = PC_AW,
  parameter logic [AW-1:0]  RESET_VEC = AW'(RESET_VEC_DEF),
  parameter logic [AW-1:0]  TRAP_VEC  = AW'(TRAP_VEC_DEF),
  parameter int             RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          resume,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jmp,
  input  logic          call,
  input  logic [AW-1:0] jmp_target,
  input  logic          ret,
  input  logic          trap,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_next,
  output logic          inst_valid,
  output logic          ras_ovf,
  output logic          ras_unf
);

  seq_state_t    r_state;
  seq_state_t    w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_inc;

`ifdef PC_SEQ_RAS_EN
  logic          w_push;
  logic          w_pop;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic [AW-1:0] w_ras_top;
  logic          w_ras_full;
  logic          w_ras_empty;
  logic          r_ovf;
  logic          r_unf;
`else
  logic          w_unused_ret;
  assign w_unused_ret = ret;
`endif

  assign w_pc_inc = r_pc + AW'(1);

  always_comb begin
    pc_next      = r_pc;
    w_state_next = r_state;
`ifdef PC_SEQ_RAS_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
`endif
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (trap) begin
            pc_next = TRAP_VEC;
          end else if (halt_req) begin
            w_state_next = ST_HALT;
`ifdef PC_SEQ_RAS_EN
          end else if (ret) begin
            if (w_ras_empty) begin
              pc_next   = w_pc_inc;
              w_set_unf = 1'b1;
            end else begin
              pc_next = w_ras_top;
              w_pop   = 1'b1;
            end
          end else if (call) begin
            pc_next   = jmp_target;
            w_push    = 1'b1;
            w_set_ovf = w_ras_full;
`endif
          end else if (jmp || call) begin
            pc_next = jmp_target;
          end else if (br_taken) begin
            pc_next = br_target;
          end else begin
            pc_next = w_pc_inc;
          end
        end
      end
      ST_HALT: if (resume) w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VEC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= pc_next;
    end
  end

  assign pc_out     = r_pc;
  assign inst_valid = (r_state == ST_RUN);

`ifdef PC_SEQ_RAS_EN
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow PC_SEQ_RAS_EN when set.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt_req, resume, br_taken, jmp, call, ret, trap;
  logic [15:0] br_target, jmp_target;
  logic [15:0] pc_out, pc_next;
  logic        inst_valid, ras_ovf, ras_unf;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .call       (call),
    .jmp_target (jmp_target),
    .ret        (ret),
    .trap       (trap),
    .pc_out     (pc_out),
    .pc_next    (pc_next),
    .inst_valid (inst_valid),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; resume = 0; br_taken = 0; jmp = 0;
    call = 0; ret = 0; trap = 0; br_target = 16'h0; jmp_target = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jmp(input logic [15:0] t);
    idle(); jmp = 1; jmp_target = t; tick(); idle();
  endtask

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic [15:0] ret_exp [5];

  initial begin
    idle();
    rst_n = 0;
    #3;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_valid", {15'd0, inst_valid}, 16'h0);
    chk("rst_ovf", {15'd0, ras_ovf}, 16'h0);
    chk("rst_unf", {15'd0, ras_unf}, 16'h0);
    @(negedge clk); rst_n = 1;
    tick();
    chk("boot_pc", pc_out, 16'h0000);
    chk("boot_valid", {15'd0, inst_valid}, 16'h1);
    tick(); chk("inc1", pc_out, 16'h0001);
    tick(); chk("inc2", pc_out, 16'h0002);

    do_jmp(16'h0010); chk("jmp_0010", pc_out, 16'h0010);
    br_taken = 1; br_target = 16'h0040; #1;
    chk("br_pcnext", pc_next, 16'h0040);
    tick(); idle(); chk("br_taken", pc_out, 16'h0040);
    jmp = 1; jmp_target = 16'h0080; br_taken = 1; br_target = 16'h0090;
    tick(); idle(); chk("jmp_over_br", pc_out, 16'h0080);

    do_jmp(16'h0100);
    call = 1; jmp_target = 16'h0200; tick(); idle();
    chk("call", pc_out, 16'h0200);
    do_jmp(16'h0205);
    ret = 1; tick(); idle();
    chk("ret", pc_out, RAS ? 16'h0101 : 16'h0206);

    // five nested calls into a depth-4 stack, then five returns
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp_target = 16'h0400 + 16'(i * 16); tick(); idle();
    end
    chk("call5_pc", pc_out, 16'h0440);
    chk("call5_ovf", {15'd0, ras_ovf}, {15'd0, RAS});
    chk("call5_unf_clear", {15'd0, ras_unf}, 16'h0);
    if (RAS) begin
      ret_exp[0] = 16'h0431; ret_exp[1] = 16'h0421; ret_exp[2] = 16'h0411;
      ret_exp[3] = 16'h0401; ret_exp[4] = 16'h0402;
    end else begin
      ret_exp[0] = 16'h0441; ret_exp[1] = 16'h0442; ret_exp[2] = 16'h0443;
      ret_exp[3] = 16'h0444; ret_exp[4] = 16'h0445;
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1; tick(); idle();
      chk($sformatf("ret%0d", i), pc_out, ret_exp[i]);
    end
    chk("ret5_unf", {15'd0, ras_unf}, {15'd0, RAS});

    do_jmp(16'h0500);
    stall = 1; jmp = 1; jmp_target = 16'h0600;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d", i), pc_out, 16'h0500);
    end
    chk("stall_pcnext", pc_next, 16'h0500);
    stall = 0; tick(); idle();
    chk("stall_release", pc_out, 16'h0600);
    stall = 1; trap = 1;
    tick(); tick();
    chk("trap_stalled", pc_out, 16'h0600);
    stall = 0; tick(); idle();
    chk("trap", pc_out, 16'h0004);

    do_jmp(16'hFFFF);
    tick(); chk("wrap", pc_out, 16'h0000);
    tick(); chk("post_wrap", pc_out, 16'h0001);

    halt_req = 1; tick(); idle();
    chk("halt_pc", pc_out, 16'h0001);
    chk("halt_valid", {15'd0, inst_valid}, 16'h0);
    jmp = 1; jmp_target = 16'h0123; trap = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("halt_hold", pc_out, 16'h0001);
    chk("halt_pcnext", pc_next, 16'h0001);
    idle(); resume = 1; tick(); idle();
    chk("resume_pc", pc_out, 16'h0001);
    chk("resume_valid", {15'd0, inst_valid}, 16'h1);
    tick(); chk("resume_inc", pc_out, 16'h0002);

    call = 1; jmp_target = 16'h0700; tick();
    jmp_target = 16'h0710;
    #2 rst_n = 0;
    #1;
    chk("midrst_pc", pc_out, 16'h0000);
    chk("midrst_valid", {15'd0, inst_valid}, 16'h0);
    chk("midrst_ovf", {15'd0, ras_ovf}, 16'h0);
    chk("midrst_unf", {15'd0, ras_unf}, 16'h0);
    idle();
    @(negedge clk); rst_n = 1;
    tick(); chk("reboot_pc", pc_out, 16'h0000);
    tick(); chk("reboot_inc", pc_out, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
